seg7_scan: RTL and testbench

4-digit multiplexed seven-segment display driver for the board's hex display. It sits directly downstream of the divided core clock and shows a 16-bit value produced by the CPU, such as the PC or a register tap. Incoming values are double-buffered and committed only at frame boundaries, so the display never tears mid-scan.

---
 rtl/seg7_scan_if.sv | 13 +
 rtl/seg7_scan.sv | 62 ++++++
 tb/tb_seg7_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: value/strobe/control inputs and multiplexed display outputs of seg7_scan
interface seg7_scan_if;
  logic [15:0] value_in;
  logic        value_valid;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  modport master (output value_in, value_valid, blank_lz, dp_mask, input an, seg, dp, frame_tick);
  modport slave  (input value_in, value_valid, blank_lz, dp_mask, output an, seg, dp, frame_tick);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed hex display driver with frame-synchronous double buffering
module seg7_scan #(
  parameter logic [15:0] REFRESH_CNT = 16'd50000
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [15:0] cnt_q, cnt_d, disp_q, disp_d, pend_reg_q, pend_reg_d;
  logic [1:0]  idx_q, idx_d;
  logic        pend_q, pend_d, term, frame, blank;
  logic [3:0]  an_q, an_d, nib, sh;
  logic [6:0]  seg_q, seg_d, off;
  logic        dp_q, dp_d, tick_q;
  // Next-state scan position, buffer commit and the segment pattern for the digit lit next
  always_comb begin
    term       = cnt_q == REFRESH_CNT - 16'd1;
    frame      = term && idx_q == 2'd3;
    cnt_d      = term ? 16'd0 : cnt_q + 16'd1;
    idx_d      = term ? idx_q + 2'd1 : idx_q;
    pend_reg_d = bus.value_valid ? bus.value_in : pend_reg_q;
    pend_d     = !frame && (bus.value_valid || pend_q);
    disp_d     = !frame ? disp_q : bus.value_valid ? bus.value_in : pend_q ? pend_reg_q : disp_q;
    sh         = {idx_d, 2'b00};
    nib        = disp_d[sh +: 4];
    off        = {3'b000, nib} * 7'd7;
    blank      = bus.blank_lz && idx_d != 2'd0 && (disp_d >> sh) == 16'd0;
    an_d       = ~(4'b0001 << idx_d);
    seg_d      = blank ? 7'h7F : ~HEX[off +: 7];
    dp_d       = ~bus.dp_mask[idx_d];
  end
  // All state and display outputs register together so anode and segments switch on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_reg_q <= '0;
      pend_q     <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_reg_q <= pend_reg_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      tick_q     <= frame;
    end
  end
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scoreboard bench for seg7_scan with REFRESH_CNT=4
module tb_seg7_scan;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  seg7_scan_if bus ();
  seg7_scan #(.REFRESH_CNT(16'd4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask
  task automatic strobe(input logic [15:0] v);
    bus.value_in    = v;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
  endtask
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpm);
    exp_q.push_back('{an: 4'b1110, seg: s0, dp: ~dpm[0]});
    exp_q.push_back('{an: 4'b1101, seg: s1, dp: ~dpm[1]});
    exp_q.push_back('{an: 4'b1011, seg: s2, dp: ~dpm[2]});
    exp_q.push_back('{an: 4'b0111, seg: s3, dp: ~dpm[3]});
  endtask
  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = bus.frame_tick;
    end
    chk({tag, "_frame_tick"}, 16'(seen), 16'd1);
  endtask
  task automatic check_frame(input string tag);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (d != 0) repeat (4) @(negedge clk);
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_digit%0d", tag, d), 16'({bus.an, bus.seg, bus.dp}), 16'(e));
      end
    end
  endtask
  initial begin
    bus.value_in    = '0;
    bus.value_valid = 1'b0;
    bus.blank_lz    = 1'b0;
    bus.dp_mask     = 4'b0000;
    #2 reset = 1'b1;
    #1;
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_seg", 16'(bus.seg), 16'h7F);
    chk("rst_dp", 16'(bus.dp), 16'h1);
    chk("rst_tick", 16'(bus.frame_tick), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] ea;
      @(negedge clk);
      ea = ~(4'b0001 << ((n / 4) % 4));
      chk($sformatf("scan_an_%0d", n), 16'(bus.an), 16'(ea));
      chk($sformatf("scan_seg_%0d", n), 16'(bus.seg), 16'h40);
      chk($sformatf("scan_tick_%0d", n), 16'(bus.frame_tick), 16'(n == 16));
    end
    strobe(16'h1A3F);
    push_frame(7'h0E, 7'h30, 7'h08, 7'h79, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("hold_seg_%0d", n), 16'(bus.seg), 16'h40);
      @(negedge clk);
    end
    wait_frame("v1a3f");
    check_frame("v1a3f");
    bus.blank_lz = 1'b1;
    strobe(16'h0005);
    push_frame(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    wait_frame("lz0005");
    check_frame("lz0005");
    strobe(16'h0000);
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    wait_frame("lz0000");
    check_frame("lz0000");
    strobe(16'h0100);
    push_frame(7'h40, 7'h40, 7'h79, 7'h7F, 4'b0000);
    wait_frame("lz0100");
    check_frame("lz0100");
    bus.blank_lz = 1'b0;
    strobe(16'h1111);
    strobe(16'h2222);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);
    wait_frame("last_wins");
    check_frame("last_wins");
    repeat (3) @(negedge clk);
    push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b0000);
    bus.value_in    = 16'h3333;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    chk("bnd_tick", 16'(bus.frame_tick), 16'h1);
    chk("bnd_pend", 16'(dut.pend_q), 16'h0);
    check_frame("bnd3333");
    bus.dp_mask = 4'b0100;
    push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b0100);
    wait_frame("dp");
    check_frame("dp");
    bus.dp_mask = 4'b0000;
    wait_frame("pre_rst");
    strobe(16'h4444);
    repeat (8) @(negedge clk);
    chk("mid_idx", 16'(dut.idx_q), 16'h2);
    chk("mid_pend", 16'(dut.pend_q), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_an", 16'(bus.an), 16'hF);
    chk("arst_seg", 16'(bus.seg), 16'h7F);
    chk("arst_dp", 16'(bus.dp), 16'h1);
    chk("arst_pend", 16'(dut.pend_q), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_an", 16'(bus.an), 16'hE);
    chk("rel_seg", 16'(bus.seg), 16'h40);
    chk("rel_disp", dut.disp_q, 16'h0000);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    wait_frame("post_rst");
    check_frame("post_rst");
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
